dm_loader: RTL and testbench
============================

Name: dm_loader

Overview:
- Host-side loader/unloader for the data memory of the single-core matrix multiplier.
- Receives a length-prefixed byte stream, writes it into data memory from address 0, then releases the core.
- Waits for core completion, then streams the result window out of data memory.
- Owns the data-memory port and muxes it between itself and the core.

Parameters:
- ADDR_W, 16, data-memory address width; matches the core address bus.
- DUMP_BASE, 16'h0100, first data-memory address of the result window.
- DUMP_LEN, 16'd9, number of result bytes streamed out after a run; 0 means no dump.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  host byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts the byte this cycle.
- tx_data  out  8  result byte.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  host accepts tx_data.
- core_run  out  1  core enable; high only in RUN.
- core_done  in  1  core finished (level, sampled in RUN).
- core_addr  in  ADDR_W  core data-memory address.
- core_wdata  in  8  core write data (low byte of core store bus).
- core_wr  in  1  core data-memory write strobe.
- core_rdata  out  8  data-memory read data returned to the core.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wdata  out  8  data-memory write data.
- mem_wr  out  1  data-memory write enable.
- mem_rdata  in  8  data-memory read data; synchronous RAM, valid 1 cycle after address.

Behaviour:
- Reset (async, any state): state=LEN_HI; len, cnt=0; rx_ready=0, tx_valid=0, tx_data=0, core_run=0, mem_wr=0, mem_addr=0, mem_wdata=0. A reset during RUN drops core_run immediately.
- States: LEN_HI, LEN_LO, LOAD, RUN, DUMP_RD, DUMP_LAT, DUMP_TX.
- rx_ready is 1 only in LEN_HI, LEN_LO, LOAD. A byte transfers when rx_valid & rx_ready.
- LEN_HI: on transfer, len[15:8]=rx_data; go to LEN_LO.
- LEN_LO: on transfer, len[7:0]=rx_data and cnt=0.
  - If the combined len==0, go to RUN.
  - Otherwise go to LOAD.
- LOAD: on transfer, mem_addr=cnt, mem_wdata=rx_data, mem_wr=1 (registered, one-cycle pulse).
  - cnt increments.
  - When cnt==len-1 at the transfer, go to RUN. Stalls while rx_valid=0.
- RUN: core_run=1, registered, so it rises the cycle after entering RUN.
  - mem_addr, mem_wdata, mem_wr are combinationally driven from core_addr, core_wdata, core_wr.
  - core_rdata=mem_rdata in all states.
  - When core_done=1: core_run=0 next cycle and cnt=0.
    - If DUMP_LEN==0, go to LEN_HI.
    - Otherwise go to DUMP_RD.
  - Core strobes are ignored outside RUN.
- DUMP_RD: mem_addr=DUMP_BASE+cnt, mem_wr=0; go to DUMP_LAT.
- DUMP_LAT: tx_data=mem_rdata, tx_valid=1; go to DUMP_TX.
- DUMP_TX: hold tx_data and tx_valid until tx_ready.
  - On handshake: tx_valid=0, cnt++.
  - If cnt==DUMP_LEN-1, go to LEN_HI; otherwise go to DUMP_RD.
  - Throughput is 1 byte per 3 cycles minimum.
- Address arithmetic is modulo 2^ADDR_W: DUMP_BASE+cnt wraps, and a load of len 0xFFFF ends at address 0xFFFE.
- mem_wr is never asserted by the loader and the core in the same cycle, by construction of the mux.
- tx_ready asserted outside DUMP_TX is ignored. rx bytes offered outside the rx states are not accepted (rx_ready=0).

Decomposition:
- Shared package holds:
  - the state encoding (localparam enum, 3 bits);
  - the ADDR_W default;
  - the DUMP_BASE/DUMP_LEN defaults, shared with the core memory map.
- One natural sub-module: dm_port_mux. It is the combinational select of loader vs core drive onto mem_addr/mem_wdata/mem_wr, controlled by a run flag. Everything else is the FSM in dm_loader.

Test Plan:
- Reset mid-LOAD: after 2 of 4 bytes, pulse rst → all outputs 0, state LEN_HI, next header accepted normally.
- Load: stream 00 04 11 22 33 44 with rx_valid gaps → mem writes 0x11@0, 0x22@1, 0x33@2, 0x44@3; core_run rises 1 cycle after the last write.
- Zero length: stream 00 00 → no mem_wr pulse, core_run=1 two cycles after the second byte.
- Core pass-through: in RUN, core_addr=0x0100, core_wdata=0x5A, core_wr=1 → mem same cycle. Assert core_done → core_run=0 next cycle.
- Dump with backpressure: memory 0x0100..0x0108 = 1..9, tx_ready toggled every other cycle → tx bytes 01..09 in order, each held stable while tx_valid & !tx_ready, return to LEN_HI after byte 09.
- Wrap: DUMP_BASE=16'hFFFF, DUMP_LEN=2 → reads 0xFFFF then 0x0000.

Source files
------------

// File: rtl/dm_loader_pkg.sv
// Shared definitions for the data-memory loader: state encoding and the
// default memory-map constants also used by the core.
package dm_loader_pkg;

  localparam int          ADDR_W_DEF    = 16;
  localparam logic [15:0] DUMP_BASE_DEF = 16'h0100;
  localparam logic [15:0] DUMP_LEN_DEF  = 16'd9;

  typedef enum logic [2:0] {
    ST_LEN_HI   = 3'd0,
    ST_LEN_LO   = 3'd1,
    ST_LOAD     = 3'd2,
    ST_RUN      = 3'd3,
    ST_DUMP_RD  = 3'd4,
    ST_DUMP_LAT = 3'd5,
    ST_DUMP_TX  = 3'd6
  } state_t;

  function automatic logic is_rx_state(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/dm_loader_if.sv
// Host byte streams, core memory port and data-memory port of the loader.
// slave is the loader's view; master is the surrounding system's view.
interface dm_loader_if
  import dm_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              core_run;
  logic              core_done;
  logic [ADDR_W-1:0] core_addr;
  logic [7:0]        core_wdata;
  logic              core_wr;
  logic [7:0]        core_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_wr;
  logic [7:0]        mem_rdata;

  modport slave (
    input  rx_data, rx_valid, tx_ready, core_done, core_addr, core_wdata, core_wr, mem_rdata,
    output rx_ready, tx_data, tx_valid, core_run, core_rdata, mem_addr, mem_wdata, mem_wr
  );

  modport master (
    output rx_data, rx_valid, tx_ready, core_done, core_addr, core_wdata, core_wr, mem_rdata,
    input  rx_ready, tx_data, tx_valid, core_run, core_rdata, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/dm_port_mux.sv
// Selects who drives the data-memory port: the core while it runs, the
// loader otherwise, so the two write strobes can never collide.
module dm_port_mux #(
  parameter int ADDR_W = 16
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_wdata,
  input  logic              core_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wr
);
  assign mem_addr  = run ? core_addr  : ld_addr;
  assign mem_wdata = run ? core_wdata : ld_wdata;
  assign mem_wr    = run ? core_wr    : ld_wr;
endmodule

// File: rtl/dm_loader.sv
// Loads a length-prefixed byte stream into data memory, runs the core, then
// streams the result window back to the host.
module dm_loader
  import dm_loader_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] DUMP_BASE = ADDR_W'(DUMP_BASE_DEF),
  parameter logic [15:0]       DUMP_LEN  = DUMP_LEN_DEF
) (
  input logic        clk,
  input logic        rst,
  dm_loader_if.slave bus
);
  state_t            state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] ld_addr_reg, ld_addr_next;
  logic [7:0]        ld_wdata_reg, ld_wdata_next;
  logic              ld_wr_reg, ld_wr_next;
  logic              rx_ready_reg, rx_ready_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic              core_run_reg, core_run_next;
  logic              rx_fire, tx_fire;
  logic [15:0]       len_full;

  assign rx_fire  = bus.rx_valid & rx_ready_reg;
  assign tx_fire  = tx_valid_reg & bus.tx_ready;
  assign len_full = {len_reg[15:8], bus.rx_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_LEN_HI;
      len_reg      <= '0;
      cnt_reg      <= '0;
      ld_addr_reg  <= '0;
      ld_wdata_reg <= '0;
      ld_wr_reg    <= 1'b0;
      rx_ready_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      core_run_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      cnt_reg      <= cnt_next;
      ld_addr_reg  <= ld_addr_next;
      ld_wdata_reg <= ld_wdata_next;
      ld_wr_reg    <= ld_wr_next;
      rx_ready_reg <= rx_ready_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      core_run_reg <= core_run_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    cnt_next      = cnt_reg;
    ld_addr_next  = ld_addr_reg;
    ld_wdata_next = ld_wdata_reg;
    ld_wr_next    = 1'b0;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    core_run_next = 1'b0;
    case (state_reg)
      ST_LEN_HI: if (rx_fire) begin
        len_next[15:8] = bus.rx_data;
        state_next     = ST_LEN_LO;
      end
      ST_LEN_LO: if (rx_fire) begin
        len_next   = len_full;
        cnt_next   = '0;
        state_next = (len_full == 16'd0) ? ST_RUN : ST_LOAD;
      end
      ST_LOAD: if (rx_fire) begin
        ld_addr_next  = cnt_reg;
        ld_wdata_next = bus.rx_data;
        ld_wr_next    = 1'b1;
        cnt_next      = cnt_reg + 1'b1;
        if (cnt_reg == ADDR_W'(len_reg - 16'd1)) state_next = ST_RUN;
      end
      ST_RUN: begin
        core_run_next = 1'b1;
        if (bus.core_done) begin
          core_run_next = 1'b0;
          cnt_next      = '0;
          // Address is set up on entry so the RAM sees it during DUMP_RD.
          ld_addr_next  = DUMP_BASE;
          state_next    = (DUMP_LEN == 16'd0) ? ST_LEN_HI : ST_DUMP_RD;
        end
      end
      ST_DUMP_RD:  state_next = ST_DUMP_LAT;
      ST_DUMP_LAT: begin
        tx_data_next  = bus.mem_rdata;
        tx_valid_next = 1'b1;
        state_next    = ST_DUMP_TX;
      end
      ST_DUMP_TX: if (tx_fire) begin
        tx_valid_next = 1'b0;
        cnt_next      = cnt_reg + 1'b1;
        ld_addr_next  = DUMP_BASE + cnt_reg + 1'b1;
        state_next    = (cnt_reg == ADDR_W'(DUMP_LEN - 16'd1)) ? ST_LEN_HI : ST_DUMP_RD;
      end
      default: state_next = ST_LEN_HI;
    endcase
    rx_ready_next = is_rx_state(state_next);
  end

  dm_port_mux #(.ADDR_W(ADDR_W)) u_mux (
    .run        (core_run_reg),
    .ld_addr    (ld_addr_reg),
    .ld_wdata   (ld_wdata_reg),
    .ld_wr      (ld_wr_reg),
    .core_addr  (bus.core_addr),
    .core_wdata (bus.core_wdata),
    .core_wr    (bus.core_wr),
    .mem_addr   (bus.mem_addr),
    .mem_wdata  (bus.mem_wdata),
    .mem_wr     (bus.mem_wr)
  );

  assign bus.rx_ready   = rx_ready_reg;
  assign bus.tx_data    = tx_data_reg;
  assign bus.tx_valid   = tx_valid_reg;
  assign bus.core_run   = core_run_reg;
  assign bus.core_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_dm_loader.sv
// Bench for dm_loader: a default instance plus a wrapped-window instance
// sharing stimulus, each with its own synchronous RAM.
module tb_dm_loader;
  localparam int DLEN = 9;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk, rst;
  logic [7:0]  rx_data, core_wdata;
  logic        rx_valid, tx_ready, core_done, core_wr;
  logic [15:0] core_addr;

  logic [7:0]  ram_a   [0:65535];
  logic [7:0]  ram_w   [0:65535];
  logic [7:0]  ref_mem [0:65535];
  wr_t         wq_a[$];
  logic [7:0]  txq_w[$];
  int          total = 0;
  int          bad = 0;

  dm_loader_if #(.ADDR_W(16)) ifa ();
  dm_loader_if #(.ADDR_W(16)) ifw ();

  dm_loader #(.ADDR_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  dm_loader #(.ADDR_W(16), .DUMP_BASE(16'hFFFF), .DUMP_LEN(16'd2)) dut_w (
    .clk(clk), .rst(rst), .bus(ifw.slave));

  assign ifa.rx_data = rx_data;   assign ifw.rx_data = rx_data;
  assign ifa.rx_valid = rx_valid; assign ifw.rx_valid = rx_valid;
  assign ifa.tx_ready = tx_ready; assign ifw.tx_ready = tx_ready;
  assign ifa.core_done = core_done;   assign ifw.core_done = core_done;
  assign ifa.core_addr = core_addr;   assign ifw.core_addr = core_addr;
  assign ifa.core_wdata = core_wdata; assign ifw.core_wdata = core_wdata;
  assign ifa.core_wr = core_wr;       assign ifw.core_wr = core_wr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifa.mem_wr) ram_a[ifa.mem_addr] <= ifa.mem_wdata;
    ifa.mem_rdata <= ram_a[ifa.mem_addr];
    if (ifw.mem_wr) ram_w[ifw.mem_addr] <= ifw.mem_wdata;
    ifw.mem_rdata <= ram_w[ifw.mem_addr];
    if (ifa.mem_wr) wq_a.push_back({ifa.mem_addr, ifa.mem_wdata});
    if (ifw.tx_valid && ifw.tx_ready) txq_w.push_back(ifw.tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    while (ifa.rx_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rx_accept", ifa.rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rx_ready"}, ifa.rx_ready, 0);
    chk({tag, "_tx_valid"}, ifa.tx_valid, 0);
    chk({tag, "_tx_data"},  ifa.tx_data, 0);
    chk({tag, "_core_run"}, ifa.core_run, 0);
    chk({tag, "_mem_wr"},   ifa.mem_wr, 0);
    chk({tag, "_mem_addr"}, ifa.mem_addr, 0);
    chk({tag, "_mem_wdata"}, ifa.mem_wdata, 0);
    chk({tag, "_w_core_run"}, ifw.core_run, 0);
  endtask

  initial begin
    int          len, idx, cyc, gap;
    logic [7:0]  dat [0:31];
    logic [7:0]  held_data, b;
    logic        held, tr;
    logic [15:0] ra;

    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    core_done = 1'b0; core_addr = '0; core_wdata = '0; core_wr = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      b = i[7:0] ^ 8'h5A;
      ram_a[i] = b; ram_w[i] = b; ref_mem[i] = b;
    end
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // Partial load interrupted by reset: two of four bytes land in memory.
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    ref_mem[0] = 8'hAA; ref_mem[1] = 8'hBB;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("midload_rst");
    @(negedge clk);
    rst = 1'b0;
    wq_a.delete(); txq_w.delete();

    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        len = 4; dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
      end else if (r == 1) begin
        len = 0;
      end else begin
        len = $urandom_range(1, 16);
        for (int i = 0; i < len; i++) dat[i] = 8'($urandom);
      end
      wq_a.delete();
      gap = (r == 0) ? 1 : 0;
      send_byte(8'(len >> 8), gap);
      send_byte(8'(len), gap);
      for (int i = 0; i < len; i++) begin
        gap = (r == 0) ? 1 : $urandom_range(0, 2);
        send_byte(dat[i], gap);
        ref_mem[i] = dat[i];
      end
      if (len > 0) begin
        chk("last_wr", ifa.mem_wr, 1);
        chk("last_addr", ifa.mem_addr, len - 1);
        chk("last_wdata", ifa.mem_wdata, dat[len-1]);
      end else begin
        chk("zero_no_wr", ifa.mem_wr, 0);
      end
      chk("run_not_yet", ifa.core_run, 0);
      @(negedge clk);
      chk("run_rise", ifa.core_run, 1);
      chk("wr_count", wq_a.size(), len);
      for (int i = 0; i < len && i < wq_a.size(); i++) begin
        chk("wr_addr", wq_a[i].a, i);
        chk("wr_data", wq_a[i].d, ref_mem[i]);
      end

      // Core traffic passes straight through to the memory port.
      for (int j = 0; j <= DLEN; j++) begin
        core_addr  = (j == DLEN) ? 16'hFFFF : 16'h0100 + 16'(j);
        core_wdata = (r == 0 && j < DLEN) ? 8'(j + 1) : 8'($urandom);
        core_wr    = 1'b1;
        #1;
        chk("pass_addr", ifa.mem_addr, core_addr);
        chk("pass_wdata", ifa.mem_wdata, core_wdata);
        chk("pass_wr", ifa.mem_wr, 1);
        ref_mem[core_addr] = core_wdata;
        @(negedge clk);
      end
      core_wr = 1'b0;
      ra = 16'h0100 + 16'($urandom_range(0, DLEN - 1));
      core_addr = ra;
      @(negedge clk);
      chk("core_rdata", ifa.core_rdata, ref_mem[ra]);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      chk("run_fall", ifa.core_run, 0);
      chk("dump_rx_ready", ifa.rx_ready, 0);
      wq_a.delete();
      core_addr = 16'h0100; core_wdata = 8'hEE; core_wr = 1'b1;

      idx = 0; cyc = 0; held = 1'b0; held_data = '0;
      while (idx < DLEN && cyc < 300) begin
        if (held) begin
          chk("tx_hold_valid", ifa.tx_valid, 1);
          chk("tx_hold_data", ifa.tx_data, held_data);
        end
        tr = (r == 0) ? cyc[0] : 1'($urandom_range(0, 1));
        tx_ready = tr;
        held = 1'b0;
        if (ifa.tx_valid) begin
          if (tr) begin
            chk("tx_byte", ifa.tx_data, ref_mem[16'h0100 + 16'(idx)]);
            idx++;
          end else begin
            held = 1'b1;
            held_data = ifa.tx_data;
          end
        end
        @(negedge clk);
        cyc++;
      end
      tx_ready = 1'b0; core_wr = 1'b0;
      chk("dump_count", idx, DLEN);
      chk("back_len_hi", ifa.rx_ready, 1);
      chk("tx_idle", ifa.tx_valid, 0);
      chk("no_stray_wr", wq_a.size(), 0);
      chk("wrap_count", txq_w.size(), 2);
      chk("wrap_b0", (txq_w.size() > 0) ? {24'd0, txq_w[0]} : 32'hFFFF_FFFF, ref_mem[16'hFFFF]);
      chk("wrap_b1", (txq_w.size() > 1) ? {24'd0, txq_w[1]} : 32'hFFFF_FFFF, ref_mem[0]);
      txq_w.delete();
      $display("run %0d: len=%0d dumped=%0d cycles=%0d", r, len, idx, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
